// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: byte width, frame length and the
// transmit-feeder FSM state type.
package uart_pkg;

    localparam int unsigned UART_BYTE_W  = 8;
    // Start bit + 8 data bits + stop bit.
    localparam int unsigned FRAME_CYCLES = 10;

    typedef enum logic [1:0] {
        StIdle,
        StArm,
        StDrain
    } tx_state_e;

endpackage

// File: rtl/uart_fifo_ram.sv
// Byte storage for the transmit FIFO: synchronous write and asynchronous read, so the
// head byte is visible at the read port during the same cycle it is popped.
module uart_fifo_ram import uart_pkg::*; #(
    parameter int unsigned Depth = 16,
    parameter int unsigned Aw    = 4
) (
    input  logic                   clock115200,
    input  logic                   we_i,
    input  logic [Aw-1:0]          waddr_i,
    input  logic [UART_BYTE_W-1:0] wdata_i,
    input  logic [Aw-1:0]          raddr_i,
    output logic [UART_BYTE_W-1:0] rdata_o
);

    logic [UART_BYTE_W-1:0] mem_q [Depth];

    always_ff @(posedge clock115200) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the UART transmitter one byte per frame through its data/send/ready
// handshake; tx_data is held from one pop to the next so it is stable for a whole frame.
module uart_tx_fifo import uart_pkg::*; #(
    parameter int unsigned Depth = 16,
    parameter int unsigned Aw    = $clog2(Depth)
) (
    input  logic                   clock115200,
    input  logic                   resetn,
    input  logic [UART_BYTE_W-1:0] wr_data_i,
    input  logic                   wr_en_i,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [Aw:0]            count_o,
    output logic                   overflow_o,
    output logic [UART_BYTE_W-1:0] tx_data_o,
    output logic                   tx_send_o,
    input  logic                   tx_ready_i
);

    localparam logic [Aw:0] FullCount = (Aw + 1)'(Depth);

    logic [Aw-1:0]          wr_ptr_q, wr_ptr_d;
    logic [Aw-1:0]          rd_ptr_q, rd_ptr_d;
    logic [Aw:0]            count_q, count_d;
    logic                   overflow_q, overflow_d;
    logic [UART_BYTE_W-1:0] tx_data_q, tx_data_d;
    logic                   tx_send_q, tx_send_d;
    tx_state_e              state_q, state_d;
    logic                   push, pop;
    logic [UART_BYTE_W-1:0] rd_data;

    uart_fifo_ram #(
        .Depth(Depth),
        .Aw   (Aw)
    ) u_ram (
        .clock115200(clock115200),
        .we_i       (push),
        .waddr_i    (wr_ptr_q),
        .wdata_i    (wr_data_i),
        .raddr_i    (rd_ptr_q),
        .rdata_o    (rd_data)
    );

    assign full_o     = (count_q == FullCount);
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;
    assign overflow_o = overflow_q;
    assign tx_data_o  = tx_data_q;
    assign tx_send_o  = tx_send_q;

    // Full is judged on the registered count, so a same-cycle pop never frees a slot.
    assign push = wr_en_i && !full_o;
    assign pop  = (state_q == StIdle) && !empty_o && tx_ready_i;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        tx_data_d  = tx_data_q;
        tx_send_d  = tx_send_q;
        state_d    = state_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (wr_en_i && full_o) begin
            overflow_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (pop) begin
                    tx_data_d = rd_data;
                    rd_ptr_d  = rd_ptr_q + 1'b1;
                    tx_send_d = 1'b1;
                    state_d   = StArm;
                end
            end
            StArm: begin
                tx_send_d = 1'b0;
                state_d   = StDrain;
            end
            StDrain: begin
                // Ready only returns once the transmitter has finished the frame.
                if (tx_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: begin
                tx_send_d = 1'b0;
                state_d   = StIdle;
            end
        endcase

        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock115200 or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            tx_data_q  <= '0;
            tx_send_q  <= 1'b0;
            state_q    <= StIdle;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            tx_data_q  <= tx_data_d;
            tx_send_q  <= tx_send_d;
            state_q    <= state_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a behavioural transmitter drives tx_ready and the serial line, and a
// queue-based model predicts pop timing, tx_data, count, flags and overflow every cycle.
module tb_uart_tx_fifo;
    import uart_pkg::*;

    localparam int unsigned Depth   = 16;
    localparam int          PopGap  = 13;

    logic       clock115200 = 1'b0;
    logic       resetn      = 1'b0;
    logic [7:0] wr_data     = 8'h00;
    logic       wr_en       = 1'b0;
    logic       full, empty, overflow, tx_send, tx_ready;
    logic [4:0] count;
    logic [7:0] tx_data;

    always #5 clock115200 = ~clock115200;

    uart_tx_fifo dut (
        .clock115200(clock115200),
        .resetn     (resetn),
        .wr_data_i  (wr_data),
        .wr_en_i    (wr_en),
        .full_o     (full),
        .empty_o    (empty),
        .count_o    (count),
        .overflow_o (overflow),
        .tx_data_o  (tx_data),
        .tx_send_o  (tx_send),
        .tx_ready_i (tx_ready)
    );

    // Transmitter stand-in: samples send while idle, shifts tx_data out LSB first, then stop.
    int unsigned tx_phase;
    logic        tx_line;
    always @(posedge clock115200 or negedge resetn) begin
        if (!resetn) begin
            tx_phase <= 0;
            tx_ready <= 1'b0;
            tx_line  <= 1'b1;
        end else if (tx_phase == 0) begin
            if (tx_send) begin
                tx_phase <= 1;
                tx_ready <= 1'b0;
                tx_line  <= 1'b0;
            end else begin
                tx_ready <= 1'b1;
            end
        end else if (tx_phase < FRAME_CYCLES - 1) begin
            tx_line  <= tx_data[tx_phase-1];
            tx_phase <= tx_phase + 1;
        end else begin
            tx_phase <= 0;
            tx_line  <= 1'b1;
        end
    end

    // Reference model state.
    logic [7:0] mq[$];
    logic [7:0] exp_data;
    logic       exp_ovf;
    int         edge_n;
    int         next_pop;
    int         total;
    int         bad;
    bit         ff_sent;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One clock: drive inputs at the falling edge, advance the model at the rising edge,
    // then compare every output just after it.
    task automatic cyc(input bit en, input logic [7:0] d);
        bit pop;
        int sz;
        @(negedge clock115200);
        wr_en   = en;
        wr_data = d;
        @(posedge clock115200);
        edge_n++;
        sz  = mq.size();
        pop = (sz > 0) && (edge_n >= next_pop);
        if (pop) begin
            exp_data = mq.pop_front();
            next_pop = edge_n + PopGap;
        end
        if (en) begin
            if (sz < Depth) mq.push_back(d);
            else exp_ovf = 1'b1;
        end
        #1;
        if (tx_send === 1'b1 && tx_data === 8'hFF) ff_sent = 1'b1;
        chk("tx_send", 32'(tx_send), 32'(pop));
        chk("tx_data", 32'(tx_data), 32'(exp_data));
        chk("count", 32'(count), 32'(mq.size()));
        chk("empty", 32'(empty), 32'(mq.size() == 0));
        chk("full", 32'(full), 32'(mq.size() == Depth));
        chk("overflow", 32'(overflow), 32'(exp_ovf));
    endtask

    task automatic release_reset();
        @(posedge clock115200);
        #2;
        resetn   = 1'b1;
        // Transmitter shows ready after its first idle edge; first pop one edge later.
        next_pop = edge_n + 2;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_send"}, 32'(tx_send), 32'd0);
        chk({tag, "_data"}, 32'(tx_data), 32'd0);
        chk({tag, "_count"}, 32'(count), 32'd0);
        chk({tag, "_empty"}, 32'(empty), 32'd1);
        chk({tag, "_full"}, 32'(full), 32'd0);
        chk({tag, "_ovf"}, 32'(overflow), 32'd0);
    endtask

    initial begin
        logic       line_seen [10];
        logic [7:0] b;
        int         pops;

        total    = 0;
        bad      = 0;
        edge_n   = 0;
        exp_data = 8'h00;
        exp_ovf  = 1'b0;
        ff_sent  = 1'b0;

        // Reset state.
        repeat (2) @(posedge clock115200);
        #1;
        check_reset_state("rst");
        release_reset();

        // Single byte A5: pop one edge after the write, then check the serial frame.
        cyc(1'b1, 8'hA5);
        cyc(1'b0, 8'h00);
        chk("t1_pulse", 32'(tx_send), 32'd1);
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, 8'h00);
            line_seen[i] = tx_line;
        end
        b = 8'hA5;
        chk("t1_start", 32'(line_seen[0]), 32'd0);
        for (int i = 0; i < 8; i++) begin
            chk("t1_bit", 32'(line_seen[i+1]), 32'((b >> i) & 8'h01));
        end
        chk("t1_stop", 32'(line_seen[9]), 32'd1);
        chk("t1_empty", 32'(empty), 32'd1);

        // Burst of incrementing bytes until the FIFO is full, then one extra FF is dropped.
        b = 8'h01;
        for (int i = 0; i < 40 && mq.size() < Depth; i++) begin
            cyc(1'b1, b);
            b = b + 8'h01;
        end
        chk("t2_full", 32'(full), 32'd1);
        chk("t2_no_ovf", 32'(overflow), 32'd0);
        cyc(1'b1, 8'hFF);
        chk("t3_ovf", 32'(overflow), 32'd1);
        chk("t3_count", 32'(count), 32'(Depth));

        // Drain; every pop must be PopGap apart and in order, FF never appears.
        pops = 0;
        for (int i = 0; i < Depth * PopGap + 20; i++) begin
            cyc(1'b0, 8'h00);
            if (tx_send === 1'b1) pops++;
        end
        chk("t3_drained", 32'(empty), 32'd1);
        chk("t3_ovf_sticky", 32'(overflow), 32'd1);
        chk("t3_no_ff", 32'(ff_sent), 32'd0);
        chk("t3_pops", 32'(pops), 32'(Depth));

        // Random traffic: same-cycle writes and pops, pointer wrap, occasional overflow.
        for (int i = 0; i < 300; i++) begin
            cyc($urandom_range(0, 9) == 0, 8'($urandom));
        end
        for (int i = 0; i < 150; i++) begin
            cyc($urandom_range(0, 9) < 3, 8'($urandom));
        end
        for (int i = 0; i < Depth * PopGap + 20; i++) begin
            cyc(1'b0, 8'h00);
        end

        // Reset in the middle of a frame, after data bit 3 has gone out.
        cyc(1'b1, 8'h3C);
        for (int i = 0; i < 20 && tx_send !== 1'b1; i++) begin
            cyc(1'b0, 8'h00);
        end
        chk("t6_popped", 32'(tx_send), 32'd1);
        repeat (5) cyc(1'b0, 8'h00);
        #2;
        resetn = 1'b0;
        #1;
        mq.delete();
        exp_data = 8'h00;
        exp_ovf  = 1'b0;
        check_reset_state("t6");
        release_reset();
        for (int i = 0; i < 20; i++) begin
            cyc(1'b0, 8'h00);
        end
        cyc(1'b1, 8'h5A);
        for (int i = 0; i < 20; i++) begin
            cyc(1'b0, 8'h00);
        end
        chk("t6_after", 32'(tx_data), 32'h5A);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
